// File: rtl/agu_issue_arbiter_pkg.sv
// Shared AGU/LSU types: uop and branch records, sequence-number width and age compares.
package agu_issue_arbiter_pkg;

    localparam int SQN_W = 6;

    typedef logic [SQN_W-1:0] SqN;

    typedef enum logic {
        PORT_LD = 1'b0,
        PORT_ST = 1'b1
    } port_e;

    typedef struct packed {
        logic        valid;
        SqN          sqN;
        logic [15:0] imm;
        logic [4:0]  tagDst;
    } EX_UOp;

    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;

    // True when a is older than b, i.e. the wrapped difference a-b is negative.
    function automatic logic sqn_older(input SqN a, input SqN b);
        SqN d;
        d = a - b;
        return d[SQN_W-1];
    endfunction

    // True when a is strictly younger than b (wrapped difference a-b positive).
    function automatic logic sqn_younger(input SqN a, input SqN b);
        SqN d;
        d = a - b;
        return !d[SQN_W-1] && (d != '0);
    endfunction

endpackage

// File: rtl/agu_arb_slot.sv
// One issue-port slot: single-entry uop buffer, branch-flush filter and starvation counter.
module agu_arb_slot
    import agu_issue_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  EX_UOp            i_uop,
    input  BranchProv        i_branch,
    input  logic             i_grant,
    input  logic             i_other_grant,
    output logic             o_ready,
    output logic             o_eligible,
    output EX_UOp            o_buf,
    output logic [CNT_W-1:0] o_cnt
);

    EX_UOp            r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             w_flush;
    logic             w_in_kill;
    logic             w_accept;

    assign w_flush    = i_branch.taken && r_buf.valid && sqn_younger(r_buf.sqN, i_branch.sqN);
    assign w_in_kill  = i_branch.taken && sqn_younger(i_uop.sqN, i_branch.sqN);
    assign o_eligible = r_buf.valid && !w_flush;
    // The slot frees up in the same cycle its uop is granted, so refill is back-to-back.
    assign o_ready    = rst && (!r_buf.valid || i_grant);
    assign w_accept   = i_uop.valid && o_ready;
    assign o_buf      = r_buf;
    assign o_cnt      = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_buf       <= i_uop;
                r_buf.valid <= !w_in_kill;
            end else if (i_grant || w_flush) begin
                r_buf.valid <= 1'b0;
            end

            if (!r_buf.valid || i_grant) begin
                r_cnt <= '0;
            end else if (i_other_grant && (r_cnt != CNT_W'(STARVE_LIMIT))) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/agu_issue_arbiter.sv
// Two-port (load/store) issue arbiter for the single AGU: oldest-first pick with
// starvation override, branch flush, and a stall-aware output register.
module agu_issue_arbiter
    import agu_issue_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  BranchProv       IN_branch,
    input  logic            IN_stall,
    input  EX_UOp [1:0]     IN_uop,
    output logic  [1:0]     OUT_ready,
    output EX_UOp           OUT_uop,
    output logic            OUT_grantPort
);

    EX_UOp                  r_out;
    port_e                  r_grant_port;
    logic [1:0]             w_eligible;
    logic [1:0]             w_grant;
    EX_UOp [1:0]            w_buf;
    logic [1:0][CNT_W-1:0]  w_cnt;
    logic                   w_any;
    logic                   w_pick;
    logic                   w_older;
    logic                   w_loser;
    logic                   w_advance;
    logic                   w_out_flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            agu_arb_slot #(
                .STARVE_LIMIT (STARVE_LIMIT),
                .CNT_W        (CNT_W)
            ) u_slot (
                .clk           (clk),
                .rst           (rst),
                .i_uop         (IN_uop[gi]),
                .i_branch      (IN_branch),
                .i_grant       (w_grant[gi]),
                .i_other_grant (w_grant[1-gi]),
                .o_ready       (OUT_ready[gi]),
                .o_eligible    (w_eligible[gi]),
                .o_buf         (w_buf[gi]),
                .o_cnt         (w_cnt[gi])
            );
        end
    endgenerate

    always_comb begin
        w_any   = 1'b0;
        w_pick  = 1'b0;
        w_older = sqn_older(w_buf[0].sqN, w_buf[1].sqN) ? 1'b0 : 1'b1;
        w_loser = ~w_older;
        if (w_eligible == 2'b11) begin
            w_any  = 1'b1;
            w_pick = (w_cnt[w_loser] == CNT_W'(STARVE_LIMIT)) ? w_loser : w_older;
        end else if (w_eligible[0]) begin
            w_any  = 1'b1;
            w_pick = 1'b0;
        end else if (w_eligible[1]) begin
            w_any  = 1'b1;
            w_pick = 1'b1;
        end
    end

    assign w_advance   = !IN_stall || !r_out.valid;
    assign w_grant     = (w_advance && w_any) ? (2'b01 << w_pick) : 2'b00;
    assign w_out_flush = IN_branch.taken && r_out.valid && sqn_younger(r_out.sqN, IN_branch.sqN);

    // A flush kills the held uop even while stalled; a fresh grant replaces it anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out        <= '0;
            r_grant_port <= PORT_LD;
        end else if (w_advance) begin
            if (w_any) begin
                r_out        <= w_buf[w_pick];
                r_grant_port <= port_e'(w_pick);
            end else begin
                r_out.valid  <= 1'b0;
            end
        end else if (w_out_flush) begin
            r_out.valid <= 1'b0;
        end
    end

    assign OUT_uop       = r_out;
    assign OUT_grantPort = r_grant_port;

endmodule

// File: tb/tb_agu_issue_arbiter.sv
// Randomized and directed checks of agu_issue_arbiter against a cycle-level reference model.
module tb_agu_issue_arbiter;
    import agu_issue_arbiter_pkg::*;

    localparam int LIMIT = 4;
    localparam int MODV  = 1 << SQN_W;

    logic        clk = 1'b0;
    logic        rst;
    BranchProv   br;
    logic        stall;
    EX_UOp [1:0] uin;
    logic  [1:0] rdy;
    EX_UOp       uout;
    logic        gp;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: one slot per port plus the AGU output register.
    int m_bv[2], m_bsq[2], m_bpay[2], m_cnt[2];
    int m_ov, m_osq, m_opay, m_gp;

    always #5 clk = ~clk;

    agu_issue_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .IN_branch     (br),
        .IN_stall      (stall),
        .IN_uop        (uin),
        .OUT_ready     (rdy),
        .OUT_uop       (uout),
        .OUT_grantPort (gp)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Wrapped signed distance a-b in sequence-number space.
    function automatic int sdiff(input int a, input int b);
        int d;
        d = (a - b) % MODV;
        if (d < 0) d += MODV;
        return (d >= MODV / 2) ? d - MODV : d;
    endfunction

    function automatic EX_UOp mk(input bit v, input int s, input int p);
        EX_UOp u;
        u.valid = v;
        u.sqN = SqN'(s);
        {u.imm, u.tagDst} = 21'(p);
        return u;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_bv[i] = 0; m_bsq[i] = 0; m_bpay[i] = 0; m_cnt[i] = 0;
        end
        m_ov = 0; m_osq = 0; m_opay = 0; m_gp = 0;
    endfunction

    // Drive one cycle (called at negedge), check against the model, then advance the model.
    task automatic step(input bit v0, input int s0, input bit v1, input int s1,
                        input bit st, input bit tk, input int bs);
        int iv[2], is[2], ip[2], fl[2], el[2], rd[2];
        int adv, g, w, l;
        iv[0] = v0; is[0] = s0 % MODV; ip[0] = int'($urandom_range(0, (1 << 21) - 1));
        iv[1] = v1; is[1] = s1 % MODV; ip[1] = int'($urandom_range(0, (1 << 21) - 1));
        uin[0] = mk(v0, is[0], ip[0]);
        uin[1] = mk(v1, is[1], ip[1]);
        stall = st;
        br.taken = tk;
        br.sqN = SqN'(bs);
        #1;
        for (int i = 0; i < 2; i++) begin
            fl[i] = (tk && m_bv[i] != 0 && sdiff(m_bsq[i], bs) > 0) ? 1 : 0;
            el[i] = (m_bv[i] != 0 && fl[i] == 0) ? 1 : 0;
        end
        adv = (!st || m_ov == 0) ? 1 : 0;
        g = -1;
        if (adv != 0) begin
            if (el[0] != 0 && el[1] != 0) begin
                w = (sdiff(m_bsq[0], m_bsq[1]) < 0) ? 0 : 1;
                l = 1 - w;
                g = (m_cnt[l] == LIMIT) ? l : w;
            end else if (el[0] != 0) g = 0;
            else if (el[1] != 0) g = 1;
        end
        for (int i = 0; i < 2; i++) rd[i] = (m_bv[i] == 0 || g == i) ? 1 : 0;

        check_val("ready0", 32'(rdy[0]), 32'(rd[0]));
        check_val("ready1", 32'(rdy[1]), 32'(rd[1]));
        check_val("out_valid", 32'(uout.valid), 32'(m_ov));
        check_val("grant_port", 32'(gp), 32'(m_gp));
        if (m_ov != 0) begin
            check_val("out_sqn", 32'(uout.sqN), 32'(m_osq));
            check_val("out_payload", 32'({uout.imm, uout.tagDst}), 32'(m_opay));
        end

        if (adv != 0) begin
            if (g >= 0) begin
                m_ov = 1; m_osq = m_bsq[g]; m_opay = m_bpay[g]; m_gp = g;
            end else m_ov = 0;
        end else if (tk && m_ov != 0 && sdiff(m_osq, bs) > 0) m_ov = 0;
        for (int i = 0; i < 2; i++) begin
            if (m_bv[i] == 0 || g == i) m_cnt[i] = 0;
            else if (g == 1 - i && m_cnt[i] < LIMIT) m_cnt[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            if (iv[i] != 0 && rd[i] != 0) begin
                m_bv[i] = (tk && sdiff(is[i], bs) > 0) ? 0 : 1;
                m_bsq[i] = is[i]; m_bpay[i] = ip[i];
            end else if (g == i || fl[i] != 0) m_bv[i] = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_out(input string tag, input int sq, input int port);
        check_val({tag, "_valid"}, 32'(uout.valid), 32'd1);
        check_val({tag, "_sqn"}, 32'(uout.sqN), 32'(sq));
        check_val({tag, "_port"}, 32'(gp), 32'(port));
    endtask

    // Assert reset at a negedge with live requests; everything must clear asynchronously.
    task automatic do_reset();
        uin[0] = mk(1, int'($urandom_range(0, MODV - 1)), 1);
        uin[1] = mk(1, int'($urandom_range(0, MODV - 1)), 2);
        rst = 1'b0;
        #1;
        check_val("rst_ready", 32'(rdy), 32'd0);
        check_val("rst_out_valid", 32'(uout.valid), 32'd0);
        check_val("rst_grant_port", 32'(gp), 32'd0);
        model_reset();
        @(negedge clk);
        check_val("rst_ready_hold", 32'(rdy), 32'd0);
        rst = 1'b1;
        uin = '0;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        br = '0;
        uin = '0;
        model_reset();
        #2;
        @(negedge clk);
        do_reset();

        // Single load: accepted, then issued one edge later.
        step(1, 5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        expect_out("single", 5, 0);
        idle(2);

        // Age pick: the older store goes first.
        step(1, 10, 1, 8, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        expect_out("age_first", 8, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        expect_out("age_second", 10, 0);
        idle(2);

        // Wrap-around: 62 is older than 1.
        step(1, 62, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        expect_out("wrap", 62, 0);
        idle(3);

        // Starvation: store 40 loses four times to older loads, then is forced through.
        step(1, 30, 1, 40, 0, 0, 0);
        for (int k = 1; k <= 5; k++) step(1, 30 + k, 0, 0, 0, 0, 0);
        expect_out("starve", 40, 1);
        for (int k = 6; k <= 8; k++) step(1, 30 + k, 0, 0, 0, 0, 0);
        idle(4);

        // Flush: OUT=18, buffers 12 / 20, branch 15 taken.
        step(1, 18, 0, 0, 0, 0, 0);
        step(1, 12, 1, 20, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 15);
        expect_out("flush_next", 12, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check_val("flush_cleared", 32'(uout.valid), 32'd0);
        idle(2);

        // Stall: OUT=7 held for three stalled cycles while both buffers fill.
        step(1, 7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 8, 1, 9, 1, 0, 0);
        expect_out("stall_hold", 7, 0);
        for (int k = 0; k < 4; k++) step(1, 10 + k, 0, 0, 0, 0, 0);
        idle(3);

        // Random traffic with occasional mid-run resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, int'($urandom_range(0, MODV - 1)),
                     $urandom_range(0, 3) != 0, int'($urandom_range(0, MODV - 1)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                     int'($urandom_range(0, MODV - 1)));
            end
        end
        // Tight age window to exercise starvation under random traffic.
        for (int n = 0; n < 200; n++) begin
            step($urandom_range(0, 7) != 0, 20 + n % 4, $urandom_range(0, 7) != 0,
                 24 + int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, 1'b0, 0);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/agu_issue_arbiter.md
Name: agu_issue_arbiter

Overview:
- Shares the single AGU between two issue sources: port 0 is the load issue queue and port 1 is the store issue queue.
- Buffers one uop per port, picks the oldest by sqN, and applies a starvation override.
- Filters uops killed by a taken branch.
- Drives the AGU input uop through an output register and honours downstream stall.

Parameters:
STARVE_LIMIT, 4, number of consecutive lost arbitrations after which a waiting port is force-granted
CNT_W, 3, width of each starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
IN_branch  in  BranchProv  branch resolution (taken, sqN)
IN_stall  in  1  AGU not accepting; high means OUT_uop must hold
IN_uop[1:0]  in  EX_UOp x2  per-port uop; .valid is the request
OUT_ready[1:0]  out  2  per-port accept
OUT_uop  out  EX_UOp  registered uop to AGU; .valid qualifies it
OUT_grantPort  out  1  port index that sourced the current OUT_uop

Behaviour:
- Reset (rst low, async): buffer valids, OUT_uop.valid, OUT_grantPort and starvation counters are all 0. OUT_ready is forced to 0 while rst is low.
- Accept: a port accepts when IN_uop[i].valid && OUT_ready[i].
  - OUT_ready[i] = !buf_valid[i] || grant[i].
  - A combinational path from IN_stall to OUT_ready is permitted.
- Younger than branch: defined as $signed(sqN - IN_branch.sqN) > 0, all sqN arithmetic at package SqN width with wrap-around.
- Flush: when IN_branch.taken, every younger uop is dropped. This applies to the buffers, OUT_uop, and incoming uops in the same cycle; dropped incoming uops are still handshaken.
  - A buffer being flushed is not eligible for grant in that cycle.
  - Flush has priority over grant and over hold-on-stall.
- Advance: output advances when !IN_stall || !OUT_uop.valid.
  - Without advance, OUT_uop and all buffers hold, except for flush invalidation.
- Grant: made only on advance.
  - One eligible buffer: grant it.
  - Two eligible buffers: grant the older, i.e. port 0 if $signed(sqN0 - sqN1) < 0, else port 1.
  - Override: if the loser's counter equals STARVE_LIMIT, grant the loser instead.
- On advance with no grant, OUT_uop.valid <= 0.
- Starvation counter[i]:
  - increments when buf_valid[i] && another port is granted;
  - clears when port i is granted or its buffer is empty;
  - saturates at STARVE_LIMIT.
- Latency:
  - uop accepted at edge N sits in the buffer and can appear on OUT_uop after edge N+1 (2-cycle minimum);
  - back-to-back throughput is 1 uop/cycle per port while granted.
- Simultaneous grant and accept on the same port: the buffer is refilled with the new uop.
- Reset mid-operation discards all buffered and output uops; no partial state survives.

Decomposition:
- Shared package: EX_UOp, BranchProv, SqN width, and a function sqn_older(a,b) for the signed-difference compare, reused by the AGU and LSU.
- Natural sub-module: agu_arb_slot, one instance per port, holding the buffer, flush filter and starvation counter.
- Arbitration and the output register stay in the top.

Test Plan:
1. Reset then single load: port0 uop sqN=5 at cycle 1 → OUT_uop.valid=1, sqN=5, grantPort=0 after cycle 2; OUT_ready=0 while rst low.
2. Age pick: port0 sqN=10 and port1 sqN=8 arrive together → port1 (8) issued first, port0 (10) the next cycle.
3. Wrap-around: port0 sqN=62 and port1 sqN=1 (6-bit SqN) → port0 issued first.
4. Starvation: port1 holds sqN=40 while port0 streams older sqN 30..35 → port1 is force-granted after losing 4 times, then port0 resumes.
5. Flush: buffers hold sqN=12 (port0) and 20 (port1), OUT_uop sqN=18, branch taken sqN=15 → OUT_uop.valid drops and buffer 20 is cleared; 12 issues next cycle.
6. Stall: IN_stall=1 for 3 cycles with OUT_uop sqN=7 → OUT_uop held stable and OUT_ready stays low on full ports; 1 uop/cycle resumes after stall drops.
